// File: rtl/uc_multiciclo.sv
// Multicycle control unit for the RV64I subset datapath (add, sub, and, addi, ld, sd, beq, bne).
// Moore FSM with one Mealy term: the branch-taken PC write in BR_CMP.
module uc_multiciclo (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       igual,
  output logic [6:0] estado,
  output logic       PCWrite,
  output logic       PCSource,
  output logic       LoadIR,
  output logic       LoadA,
  output logic       LoadB,
  output logic       LoadAluOut,
  output logic       LoadMDR,
  output logic       RegWrite,
  output logic       MemToReg,
  output logic       DMemWr,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [2:0] AluFct,
  output logic [1:0] ImmSel
);

  typedef enum logic [6:0] {
    S_RESET      = 7'd0,
    S_FETCH      = 7'd1,
    S_FETCH_WAIT = 7'd2,
    S_DECODE     = 7'd3,
    S_R_EXEC     = 7'd4,
    S_WB         = 7'd5,
    S_I_EXEC     = 7'd6,
    S_ADDR       = 7'd7,
    S_LD_MEM     = 7'd8,
    S_LD_WAIT    = 7'd9,
    S_LD_WB      = 7'd10,
    S_SD_MEM     = 7'd11,
    S_BR_CMP     = 7'd12,
    S_PC_INC     = 7'd13,
    S_ILLEGAL    = 7'h7F
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_SD   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [2:0] FCT_ADD = 3'b001;
  localparam logic [2:0] FCT_SUB = 3'b010;
  localparam logic [2:0] FCT_AND = 3'b011;

  state_t     state, state_nx;
  logic [2:0] r_fct, r_fct_nx;
  logic       r_add, r_sub, r_and, r_ok;
  logic       taken;

  assign r_add = (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign r_sub = (funct3 == 3'b000) && (funct7 == 7'b0100000);
  assign r_and = (funct3 == 3'b111) && (funct7 == 7'b0000000);
  assign r_ok  = (opcode == OP_R) && (r_add || r_sub || r_and);
  assign taken = ((funct3 == 3'b000) && igual) || ((funct3 == 3'b001) && !igual);

  // The R-type ALU function is captured in DECODE so R_EXEC never looks at funct fields.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_RESET;
      r_fct <= '0;
    end else begin
      state <= state_nx;
      r_fct <= r_fct_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    r_fct_nx   = r_fct;
    PCWrite    = 1'b0;
    PCSource   = 1'b0;
    LoadIR     = 1'b0;
    LoadA      = 1'b0;
    LoadB      = 1'b0;
    LoadAluOut = 1'b0;
    LoadMDR    = 1'b0;
    RegWrite   = 1'b0;
    MemToReg   = 1'b0;
    DMemWr     = 1'b0;
    AluSrcA    = 1'b0;
    AluSrcB    = 2'd0;
    AluFct     = 3'b000;
    ImmSel     = 2'd0;

    if (state != S_RESET && state != S_ILLEGAL) begin
      case (opcode)
        OP_SD:   ImmSel = 2'd1;
        OP_BR:   ImmSel = 2'd2;
        default: ImmSel = 2'd0;
      endcase
    end

    case (state)
      S_RESET:      state_nx = S_FETCH;
      S_FETCH:      state_nx = S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        LoadIR   = 1'b1;
        state_nx = S_DECODE;
      end
      S_DECODE: begin
        LoadA      = 1'b1;
        LoadB      = 1'b1;
        LoadAluOut = 1'b1;
        AluSrcB    = 2'd2;
        AluFct     = FCT_ADD;
        r_fct_nx   = r_sub ? FCT_SUB : (r_and ? FCT_AND : FCT_ADD);
        if (r_ok)                                             state_nx = S_R_EXEC;
        else if (opcode == OP_I && funct3 == 3'b000)          state_nx = S_I_EXEC;
        else if ((opcode == OP_LD || opcode == OP_SD) && funct3 == 3'b011)
                                                              state_nx = S_ADDR;
        else if (opcode == OP_BR && funct3[2:1] == 2'b00)     state_nx = S_BR_CMP;
        else                                                  state_nx = S_ILLEGAL;
      end
      S_R_EXEC: begin
        AluSrcA    = 1'b1;
        LoadAluOut = 1'b1;
        AluFct     = r_fct;
        state_nx   = S_WB;
      end
      S_I_EXEC: begin
        AluSrcA    = 1'b1;
        AluSrcB    = 2'd2;
        AluFct     = FCT_ADD;
        LoadAluOut = 1'b1;
        state_nx   = S_WB;
      end
      S_WB: begin
        RegWrite = 1'b1;
        state_nx = S_PC_INC;
      end
      S_ADDR: begin
        AluSrcA    = 1'b1;
        AluSrcB    = 2'd2;
        AluFct     = FCT_ADD;
        LoadAluOut = 1'b1;
        state_nx   = (opcode == OP_LD) ? S_LD_MEM : S_SD_MEM;
      end
      S_LD_MEM:  state_nx = S_LD_WAIT;
      S_LD_WAIT: begin
        LoadMDR  = 1'b1;
        state_nx = S_LD_WB;
      end
      S_LD_WB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        state_nx = S_PC_INC;
      end
      S_SD_MEM: begin
        DMemWr   = 1'b1;
        state_nx = S_PC_INC;
      end
      S_BR_CMP: begin
        AluSrcA = 1'b1;
        AluFct  = FCT_SUB;
        if (taken) begin
          PCWrite  = 1'b1;
          PCSource = 1'b1;
          state_nx = S_FETCH;
        end else begin
          state_nx = S_PC_INC;
        end
      end
      S_PC_INC: begin
        AluSrcB  = 2'd1;
        AluFct   = FCT_ADD;
        PCWrite  = 1'b1;
        state_nx = S_FETCH;
      end
      S_ILLEGAL: state_nx = S_ILLEGAL;
      default:   state_nx = S_ILLEGAL;
    endcase
  end

  assign estado = state;

endmodule
